// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
    localparam logic [7:0] PS2_RSP_RESEND   = 8'hFE;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus stability filter for one open-drain PS/2 line.
// The filtered value only follows the line after FILTER_LEN identical samples.
module ps2_line_filter #(
    parameter int FILTER_LEN = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic filt_o,
    output logic fall_o
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_q;
    logic          filt_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            fall_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            fall_q <= 1'b0;
            if (sync_q[1] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                // Line has disagreed with the filtered value long enough to accept it.
                filt_q <= sync_q[1];
                fall_q <= filt_q & ~sync_q[1];
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign filt_o = filt_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_transmitter.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, shift
// data/parity/stop on device clock falls, then check the device ACK bit.
module ps2_transmitter
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 1200,
    parameter int REQ_CYCLES     = 20,
    parameter int FILTER_LEN     = 20,
    parameter int FIRST_TIMEOUT  = 150000,
    parameter int BIT_TIMEOUT    = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       kclk_i,
    input  logic       kdata_i,
    output logic       kclk_oe,
    output logic       kdata_oe
);

    localparam int TW = $clog2(max_int(max_int(FIRST_TIMEOUT, BIT_TIMEOUT),
                                       max_int(INHIBIT_CYCLES, REQ_CYCLES)) + 1);

    logic kclk_filt, kclk_fall, kdata_filt;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_kclk_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (kclk_i),
        .filt_o (kclk_filt),
        .fall_o (kclk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_kdata_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (kdata_i),
        .filt_o (kdata_filt),
        .fall_o ()
    );

    ps2_tx_state_t state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [9:0]    shreg_q, shreg_d;
    logic [3:0]    falls_q, falls_d;
    logic          kclk_oe_q, kclk_oe_d;
    logic          kdata_oe_q, kdata_oe_d;
    logic          tx_done_q, tx_done_d;
    logic          tx_err_q, tx_err_d;
    logic          timer_zero;
    logic          abort;

    assign tx_ready   = (state_q == IDLE) && kclk_filt;
    assign busy       = (state_q != IDLE);
    assign timer_zero = (timer_q == '0);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d    = state_q;
        timer_d    = timer_q;
        shreg_d    = shreg_q;
        falls_d    = falls_q;
        kclk_oe_d  = kclk_oe_q;
        kdata_oe_d = kdata_oe_q;
        tx_done_d  = 1'b0;
        tx_err_d   = 1'b0;
        abort      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    state_d    = INHIBIT;
                    kclk_oe_d  = 1'b1;
                    kdata_oe_d = 1'b0;
                    timer_d    = TW'(INHIBIT_CYCLES - 1);
                    shreg_d    = {1'b1, ~^tx_data, tx_data};
                    falls_d    = '0;
                end
            end
            INHIBIT: begin
                if (timer_zero) begin
                    state_d    = REQ;
                    kdata_oe_d = 1'b1;
                    timer_d    = TW'(REQ_CYCLES - 1);
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            REQ: begin
                if (timer_zero) begin
                    state_d   = SHIFT;
                    kclk_oe_d = 1'b0;
                    timer_d   = TW'(FIRST_TIMEOUT - 1);
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            SHIFT: begin
                if (kclk_fall) begin
                    // Device falls 1..10 present data LSB first, parity, then stop.
                    kdata_oe_d = ~shreg_q[0];
                    shreg_d    = {1'b0, shreg_q[9:1]};
                    timer_d    = TW'(BIT_TIMEOUT - 1);
                    falls_d    = falls_q + 1'b1;
                    if (falls_q == 4'd9) begin
                        state_d = ACK;
                    end
                end else if (timer_zero) begin
                    abort = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ACK: begin
                if (kclk_fall) begin
                    if (!kdata_filt) begin
                        state_d = WAIT_IDLE;
                        timer_d = TW'(BIT_TIMEOUT - 1);
                    end else begin
                        state_d  = IDLE;
                        tx_err_d = 1'b1;
                    end
                end else if (timer_zero) begin
                    abort = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (kclk_filt && kdata_filt) begin
                    state_d   = IDLE;
                    tx_done_d = 1'b1;
                end else if (timer_zero) begin
                    abort = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d    = IDLE;
            tx_err_d   = 1'b1;
            kclk_oe_d  = 1'b0;
            kdata_oe_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            shreg_q    <= '0;
            falls_q    <= '0;
            kclk_oe_q  <= 1'b0;
            kdata_oe_q <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            shreg_q    <= shreg_d;
            falls_q    <= falls_d;
            kclk_oe_q  <= kclk_oe_d;
            kdata_oe_q <= kdata_oe_d;
            tx_done_q  <= tx_done_d;
            tx_err_q   <= tx_err_d;
        end
    end

    assign kclk_oe  = kclk_oe_q;
    assign kdata_oe = kdata_oe_q;
    assign tx_done  = tx_done_q;
    assign tx_err   = tx_err_q;

endmodule

// File: tb/tb_ps2_transmitter.sv
// Bench for ps2_transmitter: a PS/2 keyboard model on the open-drain lines and
// a frame-level model of the host output timeline checked every cycle.
module tb_ps2_transmitter;
    import ps2_pkg::*;

    localparam int INHIBIT = 1200;
    localparam int REQ     = 20;
    localparam int FLT     = 20;
    localparam int FT      = 15000;
    localparam int BT      = 2000;
    localparam int HALF    = 400;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done, tx_err, kclk_oe, kdata_oe;

    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    logic glitch       = 1'b0;
    logic dev_released = 1'b0;
    logic [10:0] dev_bits;

    wire kclk_line  = ~(kclk_oe | dev_clk_low | glitch);
    wire kdata_line = ~(kdata_oe | dev_data_low);

    ps2_transmitter #(
        .INHIBIT_CYCLES (INHIBIT),
        .REQ_CYCLES     (REQ),
        .FILTER_LEN     (FLT),
        .FIRST_TIMEOUT  (FT),
        .BIT_TIMEOUT    (BT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .tx_done  (tx_done),
        .tx_err   (tx_err),
        .kclk_i   (kclk_line),
        .kdata_i  (kdata_line),
        .kclk_oe  (kclk_oe),
        .kdata_oe (kdata_oe)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Wire-level frame as the device must see it: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    // Inputs as seen by the DUT at each rising edge.
    logic s_valid = 1'b0;
    logic s_rst   = 1'b1;
    always @(posedge clk) begin
        s_valid <= tx_valid;
        s_rst   <= !rst_n;
    end

    // Frame model: cycle n after acceptance; kclk held for INHIBIT+REQ cycles,
    // kdata joins for the final REQ of them; both released once the frame ends.
    bit chk_en = 1'b0;
    bit m_busy = 1'b0;
    int m_n    = 0;
    int f_done = 0;
    int f_err  = 0;
    int end_n  = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            if (s_rst) begin
                m_busy = 1'b0;
                m_n    = 0;
            end else if (m_busy) begin
                m_n++;
                if (tx_done || tx_err) begin
                    m_busy = 1'b0;
                    end_n  = m_n;
                    f_done += int'(tx_done);
                    f_err  += int'(tx_err);
                end
            end else begin
                check("stray_done_err", {tx_done, tx_err}, 0);
                if (s_valid) begin
                    m_busy = 1'b1;
                    m_n    = 1;
                    f_done = 0;
                    f_err  = 0;
                end
            end
            check("done_err_exclusive", tx_done & tx_err, 0);
            check("busy", busy, m_busy);
            check("kclk_oe", kclk_oe, m_busy && (m_n <= INHIBIT + REQ));
            if (!m_busy || m_n <= INHIBIT + REQ)
                check("kdata_oe", kdata_oe, m_busy && (m_n > INHIBIT));
            else if (dev_released)
                check("kdata_oe_stop", kdata_oe, 0);
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Keyboard: waits for request-to-send, samples start, then clocks nfalls times,
    // sampling the host data on each rising edge and optionally driving the ACK.
    task automatic device_run(input int nfalls, input bit ack, input int glitch_k,
                              output logic [10:0] bits);
        int t;
        t    = 0;
        bits = 'x;
        dev_released = 1'b0;
        while (!(kclk_line === 1'b1 && kdata_line === 1'b0) && t < 4 * INHIBIT) begin
            @(negedge clk);
            t++;
        end
        check("rts_seen", t < 4 * INHIBIT, 1);
        if (t >= 4 * INHIBIT) return;
        repeat (HALF) @(negedge clk);
        bits[0] = kdata_line;
        for (int k = 1; k <= nfalls; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k <= 10) bits[k] = kdata_line;
            if (k == 10) dev_released = 1'b1;
            if (k == glitch_k) begin
                repeat (100) @(negedge clk);
                glitch = 1'b1;
                repeat (10) @(negedge clk);
                glitch = 1'b0;
                repeat (HALF - 110) @(negedge clk);
            end else if (k == 10 && ack) begin
                repeat (HALF / 2) @(negedge clk);
                dev_data_low = 1'b1;
                repeat (HALF / 2) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_frame_end(input int bound, input string name);
        int t;
        t = 0;
        while (m_busy && t < bound) begin
            @(negedge clk);
            t++;
        end
        check(name, m_busy, 0);
    endtask

    initial begin
        // Reset with lines idle.
        rst_n = 1'b0;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_kclk_oe", kclk_oe, 0);
        check("rst_kdata_oe", kdata_oe, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_tx_err", tx_err, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("ready_after_reset", tx_ready, 1);

        // Set-LEDs with ACK.
        fork
            send(PS2_CMD_SET_LEDS);
            device_run(11, 1'b1, 0, dev_bits);
        join
        wait_frame_end(2 * BT, "ed_frame_end");
        check("ed_bits_model", dev_bits, frame_bits(PS2_CMD_SET_LEDS));
        check("ed_bits_literal", dev_bits, 11'h7DA);
        check("ed_done_count", f_done, 1);
        check("ed_err_count", f_err, 0);

        // 0x01 without ACK: parity bit 0, single error.
        repeat (100) @(negedge clk);
        check("ready_before_01", tx_ready, 1);
        fork
            send(8'h01);
            device_run(11, 1'b0, 0, dev_bits);
        join
        wait_frame_end(2 * BT, "noack_frame_end");
        check("noack_bits_model", dev_bits, frame_bits(8'h01));
        check("noack_bits_literal", dev_bits, 11'h402);
        check("noack_err_count", f_err, 1);
        check("noack_done_count", f_done, 0);
        check("noack_kclk_oe", kclk_oe, 0);
        check("noack_kdata_oe", kdata_oe, 0);

        // Device never clocks: first-fall timeout measured from kclk release.
        repeat (100) @(negedge clk);
        fork
            send(PS2_CMD_ECHO);
            device_run(0, 1'b0, 0, dev_bits);
        join
        check("timeout_start_bit", dev_bits[0], 0);
        wait_frame_end(FT + 1000, "timeout_frame_end");
        check("timeout_cycle_model", end_n, INHIBIT + REQ + 1 + FT);
        check("timeout_cycle_literal", end_n, 16221);
        check("timeout_err_count", f_err, 1);
        check("timeout_done_count", f_done, 0);
        @(negedge clk);
        check("ready_after_timeout", tx_ready, 1);

        // Reset after fall 4 of 0xF0: data bit 3 is 0, so kdata is being pulled.
        repeat (100) @(negedge clk);
        fork
            send(8'hF0);
            device_run(4, 1'b0, 0, dev_bits);
        join
        check("midframe_kdata_pulled", kdata_oe, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midframe_kclk_oe", kclk_oe, 0);
        check("midframe_kdata_oe", kdata_oe, 0);
        check("midframe_busy", busy, 0);
        check("midframe_no_err", f_err, 0);
        check("midframe_no_done", f_done, 0);

        // 0xFF with a short kclk glitch and tx_valid pulses while busy.
        repeat (100) @(negedge clk);
        check("ready_before_ff", tx_ready, 1);
        fork
            send(PS2_CMD_RESET);
            device_run(11, 1'b1, 3, dev_bits);
            begin
                repeat (3000) @(negedge clk);
                tx_data  = 8'h00;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
                repeat (2000) @(negedge clk);
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        wait_frame_end(2 * BT, "ff_frame_end");
        check("ff_bits_model", dev_bits, frame_bits(PS2_CMD_RESET));
        check("ff_bits_literal", dev_bits, 11'h7FE);
        check("ff_done_count", f_done, 1);
        check("ff_err_count", f_err, 0);
        repeat (2000) @(negedge clk);
        check("ff_single_frame", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
